// File: rtl/hpm_counter_bank.sv
// -----------------------------------------------------------------------------
// hpm_counter_bank
//
// Hardware performance-monitor bank for the CSR file: mcycle, minstret and
// NbCounters programmable mhpmcounterN counters, each with an mhpmeventN
// selector, plus mcountinhibit. CSR reads are combinational from the read
// address; CSR writes are applied on the clock edge.
//
// Ports:
//   clk_i        system clock
//   rstn_i       asynchronous active-low reset
//   event_i      event strobes, one count per cycle while high
//   instret_i    instruction-committed strobe (minstret event)
//   csr_raddr_i  CSR read address
//   csr_rdata_o  CSR read data (combinational)
//   csr_rhit_o   read address is mapped by this block (combinational)
//   csr_wen_i    CSR write enable
//   csr_waddr_i  CSR write address
//   csr_wdata_i  CSR write data
//   overflow_o   registered one-cycle wrap pulse per programmable counter
// -----------------------------------------------------------------------------
module hpm_counter_bank #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned NbCounters   = 4,
    parameter int unsigned NbEvents     = 8,
    parameter int unsigned CounterWidth = 64
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [NbEvents-1:0]   event_i,
    input  logic                  instret_i,
    input  logic [11:0]           csr_raddr_i,
    output logic [DataWidth-1:0]  csr_rdata_o,
    output logic                  csr_rhit_o,
    input  logic                  csr_wen_i,
    input  logic [11:0]           csr_waddr_i,
    input  logic [DataWidth-1:0]  csr_wdata_i,
    output logic [NbCounters-1:0] overflow_o
);

    // -------------------------------------------------------------------------
    // Parameter legality
    // -------------------------------------------------------------------------
    if (!((DataWidth == 32) || (DataWidth == 64))) begin : g_bad_data_width
        $fatal(1, "hpm_counter_bank: DataWidth must be 32 or 64");
    end
    if ((NbCounters < 1) || (NbCounters > 29)) begin : g_bad_nb_counters
        $fatal(1, "hpm_counter_bank: NbCounters must be in 1..29");
    end
    if ((NbEvents < 1) || (NbEvents > 255)) begin : g_bad_nb_events
        $fatal(1, "hpm_counter_bank: NbEvents must be in 1..255");
    end
    if (CounterWidth != 64) begin : g_bad_counter_width
        $fatal(1, "hpm_counter_bank: CounterWidth must be 64");
    end

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam bit IsRv32 = (DataWidth == 32);
    // Counter slot k: 0 = mcycle, 1 = minstret, 2.. = mhpmcounter(3+k-2)
    localparam int NumCnt = NbCounters + 2;
    localparam int SelW   = $clog2(NbEvents + 1);
    localparam int EvtW   = 1 << SelW;

    localparam logic [11:0] AddrInhibit = 12'h320;
    localparam logic [11:0] AddrEvtBase = 12'h323;
    localparam logic [11:0] AddrCntLo   = 12'hB00;
    localparam logic [11:0] AddrCntHi   = 12'hB80;

    // Writable mcountinhibit bits: CY (0), IR (2) and one per programmable counter
    localparam logic [31:0] InhMask =
        32'h0000_0005 | (((32'h0000_0001 << NbCounters) - 32'h0000_0001) << 3);

    // CSR offset of counter slot k; this is also its mcountinhibit bit index
    function automatic logic [11:0] cnt_offset(input int k);
        logic [11:0] off;
        if (k == 0) begin
            off = 12'd0;
        end else if (k == 1) begin
            off = 12'd2;
        end else begin
            off = 12'(k + 1);
        end
        return off;
    endfunction

    // WARL legalisation of an event selector write: out-of-range selects nothing
    function automatic logic [SelW-1:0] warl_sel(input logic [DataWidth-1:0] wdata);
        logic [SelW-1:0] sel;
        if (wdata > DataWidth'(NbEvents)) begin
            sel = {SelW{1'b0}};
        end else begin
            sel = wdata[SelW-1:0];
        end
        return sel;
    endfunction

    // -------------------------------------------------------------------------
    // State and next-state signals
    // -------------------------------------------------------------------------
    logic [CounterWidth-1:0] cnt_r      [NumCnt];
    logic [CounterWidth-1:0] cnt_nxt_s  [NumCnt];
    logic [SelW-1:0]         sel_r      [NbCounters];
    logic [SelW-1:0]         sel_nxt_s  [NbCounters];
    logic [31:0]             inhibit_r;
    logic [31:0]             inhibit_nxt_s;
    logic [NbCounters-1:0]   ovf_r;
    logic [NbCounters-1:0]   ovf_nxt_s;

    logic [EvtW-1:0]         evt_vec_s;
    logic [CounterWidth-1:0] wdata_ext_s;
    logic [NumCnt-1:0]       inc_en_s;
    logic [NumCnt-1:0]       wlo_s;
    logic [NumCnt-1:0]       whi_s;

    logic [NbCounters-1:0]   rd_evt_hit_s;
    logic [NumCnt-1:0]       rd_lo_hit_s;
    logic [NumCnt-1:0]       rd_hi_hit_s;
    logic                    rd_inh_hit_s;
    logic [DataWidth-1:0]    rdata_s;
    logic                    rhit_s;

    // Event vector indexed directly by selector value; bit 0 is the
    // "no event" slot so that selector 0 never counts.
    assign evt_vec_s   = EvtW'({event_i, 1'b0});
    assign wdata_ext_s = CounterWidth'(csr_wdata_i);

    // Write-address decode for the low/high half of every counter
    always_comb begin
        wlo_s = {NumCnt{1'b0}};
        whi_s = {NumCnt{1'b0}};
        for (int k = 0; k < NumCnt; k++) begin
            wlo_s[k] = csr_wen_i && (csr_waddr_i == (AddrCntLo + cnt_offset(k)));
            whi_s[k] = IsRv32 && csr_wen_i && (csr_waddr_i == (AddrCntHi + cnt_offset(k)));
        end
    end

    // Increment enables, evaluated with the configuration held before this edge
    always_comb begin
        inc_en_s    = {NumCnt{1'b0}};
        inc_en_s[0] = ~inhibit_r[0];
        inc_en_s[1] = ~inhibit_r[2] & instret_i;
        for (int i = 0; i < NbCounters; i++) begin
            inc_en_s[i+2] = ~inhibit_r[i+3] & evt_vec_s[sel_r[i]];
        end
    end

    // Counter next value: CSR write beats increment, increment beats hold
    always_comb begin
        ovf_nxt_s = {NbCounters{1'b0}};
        for (int k = 0; k < NumCnt; k++) begin
            cnt_nxt_s[k] = cnt_r[k];
            if (wlo_s[k]) begin
                if (IsRv32) begin
                    cnt_nxt_s[k] = {cnt_r[k][CounterWidth-1:32], csr_wdata_i[31:0]};
                end else begin
                    cnt_nxt_s[k] = wdata_ext_s;
                end
            end else if (whi_s[k]) begin
                cnt_nxt_s[k] = {csr_wdata_i[31:0], cnt_r[k][31:0]};
            end else if (inc_en_s[k]) begin
                cnt_nxt_s[k] = cnt_r[k] + 64'd1;
            end else begin
                cnt_nxt_s[k] = cnt_r[k];
            end
        end
        // Wrap only counts when the increment path was taken from all-ones
        for (int i = 0; i < NbCounters; i++) begin
            ovf_nxt_s[i] = inc_en_s[i+2] & ~wlo_s[i+2] & ~whi_s[i+2] & (&cnt_r[i+2]);
        end
    end

    // Configuration next value: mcountinhibit and WARL event selectors
    always_comb begin
        inhibit_nxt_s = inhibit_r;
        if (csr_wen_i && (csr_waddr_i == AddrInhibit)) begin
            inhibit_nxt_s = csr_wdata_i[31:0] & InhMask;
        end else begin
            inhibit_nxt_s = inhibit_r;
        end
        for (int i = 0; i < NbCounters; i++) begin
            sel_nxt_s[i] = sel_r[i];
            if (csr_wen_i && (csr_waddr_i == (AddrEvtBase + 12'(i)))) begin
                sel_nxt_s[i] = warl_sel(csr_wdata_i);
            end else begin
                sel_nxt_s[i] = sel_r[i];
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < NumCnt; k++) begin
                cnt_r[k] <= 64'd0;
            end
            for (int i = 0; i < NbCounters; i++) begin
                sel_r[i] <= {SelW{1'b0}};
            end
            inhibit_r <= 32'd0;
            ovf_r     <= {NbCounters{1'b0}};
        end else begin
            for (int k = 0; k < NumCnt; k++) begin
                cnt_r[k] <= cnt_nxt_s[k];
            end
            for (int i = 0; i < NbCounters; i++) begin
                sel_r[i] <= sel_nxt_s[i];
            end
            inhibit_r <= inhibit_nxt_s;
            ovf_r     <= ovf_nxt_s;
        end
    end

    // Read-address decode; at most one hit is ever set
    always_comb begin
        rd_inh_hit_s = (csr_raddr_i == AddrInhibit);
        rd_evt_hit_s = {NbCounters{1'b0}};
        rd_lo_hit_s  = {NumCnt{1'b0}};
        rd_hi_hit_s  = {NumCnt{1'b0}};
        for (int i = 0; i < NbCounters; i++) begin
            rd_evt_hit_s[i] = (csr_raddr_i == (AddrEvtBase + 12'(i)));
        end
        for (int k = 0; k < NumCnt; k++) begin
            rd_lo_hit_s[k] = (csr_raddr_i == (AddrCntLo + cnt_offset(k)));
            rd_hi_hit_s[k] = IsRv32 && (csr_raddr_i == (AddrCntHi + cnt_offset(k)));
        end
    end

    // Read data mux as an AND-OR of the decoded hits; unmapped reads give 0
    always_comb begin
        rhit_s  = rd_inh_hit_s | (|rd_evt_hit_s) | (|rd_lo_hit_s) | (|rd_hi_hit_s);
        rdata_s = rd_inh_hit_s ? DataWidth'(inhibit_r) : {DataWidth{1'b0}};
        for (int i = 0; i < NbCounters; i++) begin
            rdata_s = rdata_s |
                      (rd_evt_hit_s[i] ? DataWidth'(sel_r[i]) : {DataWidth{1'b0}});
        end
        for (int k = 0; k < NumCnt; k++) begin
            if (IsRv32) begin
                rdata_s = rdata_s |
                          (rd_lo_hit_s[k] ? DataWidth'(cnt_r[k][31:0]) : {DataWidth{1'b0}}) |
                          (rd_hi_hit_s[k] ? DataWidth'(cnt_r[k][CounterWidth-1:32])
                                          : {DataWidth{1'b0}});
            end else begin
                rdata_s = rdata_s |
                          (rd_lo_hit_s[k] ? DataWidth'(cnt_r[k]) : {DataWidth{1'b0}});
            end
        end
    end

    assign csr_rdata_o = rdata_s;
    assign csr_rhit_o  = rhit_s;
    assign overflow_o  = ovf_r;

endmodule
